// File: rtl/alu_16_bit_core.sv
// Registered 16-bit ALU with a 17-bit result (carry/borrow/extension in bit 16).
// Outputs float when the unit was not enabled at the last edge, so units can share a bus.
module alu_16_bit_core (
  input  logic        Clock_In,
  input  logic        Reset_n_In,
  input  logic        Enable_In,
  input  logic [3:0]  ALU_Operation_Select_In,
  input  logic [15:0] Data_A_In,
  input  logic [15:0] Data_B_In,
  output logic [15:0] Result_Out,
  output logic        Carry_Out
);

  logic        r_en;
  logic [16:0] r_res;
  logic [16:0] w_f;
  logic [16:0] w_a;
  logic [16:0] w_b;
  logic [31:0] w_prod;
  logic [15:0] w_quo;
  logic [15:0] w_rem;
  logic        w_bz;

  assign w_a    = {1'b0, Data_A_In};
  assign w_b    = {1'b0, Data_B_In};
  assign w_bz   = (Data_B_In == 16'h0000);
  assign w_prod = Data_A_In * Data_B_In;
  // Divide-by-zero returns all ones / the dividend instead of trapping
  assign w_quo  = w_bz ? 16'hFFFF : Data_A_In / Data_B_In;
  assign w_rem  = w_bz ? Data_A_In : Data_A_In % Data_B_In;

  always_comb begin
    w_f = '0;
    unique case (ALU_Operation_Select_In)
      4'h0: w_f = w_a + 17'd1;
      4'h1: w_f = w_a - 17'd1;
      4'h2: w_f = w_a + w_b;
      4'h3: w_f = w_a - w_b;
      4'h4: w_f = w_b - w_a;
      4'h5: w_f = w_prod[16:0];
      4'h6: w_f = {1'b0, w_quo};
      4'h7: w_f = {1'b0, w_rem};
      4'h8: w_f = w_a & w_b;
      4'h9: w_f = w_a | w_b;
      4'hA: w_f = ~w_a;
      4'hB: w_f = ~w_b;
      4'hC: w_f = ~(w_a & w_b);
      4'hD: w_f = ~(w_a | w_b);
      4'hE: w_f = w_a ^ w_b;
      4'hF: w_f = ~(w_a ^ w_b);
    endcase
  end

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      r_en  <= 1'b0;
      r_res <= '0;
    end else begin
      r_en <= Enable_In;
      if (Enable_In)
        r_res <= w_f;
    end
  end

  assign {Carry_Out, Result_Out} = r_en ? r_res : 17'bz;

endmodule

// File: tb/tb_alu_16_bit_core.sv
// Bench for alu_16_bit_core: a model checked every cycle plus literal vectors.
// Two instances see a pulled-up and a pulled-down bus so Z is told apart from data.
module tb_alu_16_bit_core;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  wire  [16:0] w_pu;
  wire  [16:0] w_pd;

  int n_pass;
  int n_total;
  bit chk_on;

  logic        m_en;
  logic [16:0] m_res;

  for (genvar g = 0; g < 17; g++) begin : g_pull
    pullup   (w_pu[g]);
    pulldown (w_pd[g]);
  end

  alu_16_bit_core u_pu (
    .Clock_In                (clk),
    .Reset_n_In              (rst_n),
    .Enable_In               (en),
    .ALU_Operation_Select_In (op),
    .Data_A_In               (a),
    .Data_B_In               (b),
    .Result_Out              (w_pu[15:0]),
    .Carry_Out               (w_pu[16])
  );

  alu_16_bit_core u_pd (
    .Clock_In                (clk),
    .Reset_n_In              (rst_n),
    .Enable_In               (en),
    .ALU_Operation_Select_In (op),
    .Data_A_In               (a),
    .Data_B_In               (b),
    .Result_Out              (w_pd[15:0]),
    .Carry_Out               (w_pd[16])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model_f(
    input logic [3:0] f_op,
    input logic [15:0] f_a,
    input logic [15:0] f_b
  );
    longint x;
    longint ua;
    longint ub;
    ua = longint'(f_a);
    ub = longint'(f_b);
    case (f_op)
      4'h0: x = ua + 1;
      4'h1: x = ua - 1;
      4'h2: x = ua + ub;
      4'h3: x = ua - ub;
      4'h4: x = ub - ua;
      4'h5: x = ua * ub;
      4'h6: x = (ub == 0) ? 64'hFFFF : ua / ub;
      4'h7: x = (ub == 0) ? ua : ua % ub;
      4'h8: x = ua & ub;
      4'h9: x = ua | ub;
      4'hA: x = 64'h1FFFF ^ ua;
      4'hB: x = 64'h1FFFF ^ ub;
      4'hC: x = 64'h1FFFF ^ (ua & ub);
      4'hD: x = 64'h1FFFF ^ (ua | ub);
      4'hE: x = ua ^ ub;
      default: x = 64'h1FFFF ^ (ua ^ ub);
    endcase
    return x[16:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en  <= 1'b0;
      m_res <= '0;
    end else begin
      m_en <= en;
      if (en)
        m_res <= model_f(op, a, b);
    end
  end

  function automatic bit bus_z();
    return (w_pu === 17'h1FFFF) && (w_pd === 17'h00000);
  endfunction

  function automatic bit bus_is(input logic [16:0] v);
    return (w_pu === v) && (w_pd === v);
  endfunction

  task automatic chk_z(input string name);
    n_total++;
    if (bus_z()) n_pass++;
    else $display("FAIL %s: bus pu=%h pd=%h, required Z", name, w_pu, w_pd);
  endtask

  task automatic chk_v(input string name, input logic [16:0] v);
    n_total++;
    if (bus_is(v)) n_pass++;
    else $display("FAIL %s: bus pu=%h pd=%h, required %h", name, w_pu, w_pd, v);
  endtask

  // Model-driven compare on every cycle once out of reset
  always @(negedge clk) begin
    if (chk_on) begin
      if (m_en) chk_v("model", m_res);
      else chk_z("model_z");
    end
  end

  task automatic vec(
    input string name,
    input logic [3:0] v_op,
    input logic [15:0] v_a,
    input logic [15:0] v_b,
    input logic [16:0] exp
  );
    logic [16:0] mv;
    en = 1'b1;
    op = v_op;
    a  = v_a;
    b  = v_b;
    mv = model_f(v_op, v_a, v_b);
    n_total++;
    if (mv === exp) n_pass++;
    else $display("FAIL %s_model: model=%h required %h", name, mv, exp);
    @(negedge clk);
    chk_v(name, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    chk_on  = 1'b0;
    rst_n   = 1'b0;
    en      = 1'b1;
    op      = 4'h2;
    a       = 16'h1234;
    b       = 16'h1111;
    repeat (3) @(negedge clk);
    chk_z("reset_z");

    en    = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_z("idle_after_reset");
    chk_on = 1'b1;

    vec("inc_wrap", 4'h0, 16'hFFFF, 16'h0000, 17'h10000);
    vec("add_8000", 4'h2, 16'h8000, 16'h8000, 17'h10000);
    vec("add_plain", 4'h2, 16'h1234, 16'h1111, 17'h02345);
    vec("dec_wrap", 4'h1, 16'h0000, 16'h0000, 17'h1FFFF);
    vec("sub_ab", 4'h3, 16'h0005, 16'h0007, 17'h1FFFE);
    vec("sub_ba", 4'h4, 16'h0003, 16'h0009, 17'h00006);
    vec("mul", 4'h5, 16'h0100, 16'h0100, 17'h10000);
    vec("div", 4'h6, 16'h0064, 16'h0007, 17'h0000E);
    vec("mod", 4'h7, 16'h0064, 16'h0007, 17'h00002);
    vec("div_by0", 4'h6, 16'h0064, 16'h0000, 17'h0FFFF);
    vec("mod_by0", 4'h7, 16'h0064, 16'h0000, 17'h00064);
    vec("and", 4'h8, 16'hF0F0, 16'hFF00, 17'h0F000);
    vec("or", 4'h9, 16'hF0F0, 16'hFF00, 17'h0FFF0);
    vec("nota", 4'hA, 16'hF0F0, 16'hFF00, 17'h10F0F);
    vec("notb", 4'hB, 16'hF0F0, 16'hFF00, 17'h100FF);
    vec("nand", 4'hC, 16'hF0F0, 16'hFF00, 17'h10FFF);
    vec("nor", 4'hD, 16'hF0F0, 16'hFF00, 17'h1000F);
    vec("xor", 4'hE, 16'hF0F0, 16'hFF00, 17'h00FF0);
    vec("xnor", 4'hF, 16'hF0F0, 16'hFF00, 17'h1F00F);
    vec("mul_trunc", 4'h5, 16'hFFFF, 16'hFFFF, 17'h00001);

    // Disable: output floats after the next edge, result register holds
    en = 1'b0;
    op = 4'h2;
    a  = 16'h0001;
    b  = 16'h0001;
    @(negedge clk);
    chk_z("disable_z");
    @(negedge clk);

    // Mixed traffic with enable toggling, checked by the model only
    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = (i % 7 == 0) ? 16'h0000 : 16'($urandom);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of an enabled cycle
    vec("pre_reset", 4'h2, 16'h0001, 16'h0002, 17'h00003);
    en = 1'b1;
    op = 4'h2;
    a  = 16'h0010;
    b  = 16'h0020;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_z("async_reset_z");
    @(negedge clk);
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_z("post_reset_idle");
    vec("after_reset", 4'h0, 16'h0041, 16'h0000, 17'h00042);
    en = 1'b0;
    @(negedge clk);
    chk_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
